mfp_jtag_tap_master: RTL and testbench
======================================

// Module: mfp_jtag_tap_master
// PURPOSE
//  JTAG/EJTAG TAP initiator. Drives TCK/TMS/TDI/TRST_N and samples TDO to run IR and DR scans on an
//  EJTAG target (e.g. the mfp_system EJ_* debug port) from a simple command/response interface.
//  Used for board self-test and on-chip debug bring-up without an external BusBlaster probe.
// PARAMETERS
//  CLK_DIV  4   clk cycles per TCK half-period (>=1); TCK period = 2*CLK_DIV clk cycles
//  MAX_LEN  32  max scan length in bits; width of cmd_data/rsp_data
//  LEN_W    6   width of cmd_len; must hold MAX_LEN
// PORTS
//  clk        in   1        system clock
//  rst        in   1        asynchronous reset, active-high
//  cmd_valid  in   1        command present
//  cmd_ready  out  1        master accepts command this cycle
//  cmd_tlr    in   1        1: Test-Logic-Reset sequence only (len/data ignored)
//  cmd_ir     in   1        1: IR scan, 0: DR scan
//  cmd_len    in   LEN_W    scan length in bits
//  cmd_data   in   MAX_LEN  TDI bits, bit 0 shifted first
//  rsp_valid  out  1        scan result available
//  rsp_ready  in   1        consumer takes result
//  rsp_data   out  MAX_LEN  captured TDO bits, bit i = i-th shifted bit; bits >= len are 0
//  tck_o      out  1        JTAG TCK
//  tms_o      out  1        JTAG TMS
//  tdi_o      out  1        JTAG TDI
//  trst_n_o   out  1        JTAG TRST_N
//  tdo_i      in   1        JTAG TDO
// BEHAVIOUR
//  Reset values: tck_o=0, tms_o=1, tdi_o=0, cmd_ready=0, rsp_valid=0, rsp_data=0, trst_n_o see CONFIGURATION.
//  TCK: each bit = low half (CLK_DIV clk) then high half (CLK_DIV clk). tms_o/tdi_o update on the clk edge
//   that drives tck_o 1->0 (or at bit start); tdo_i sampled on the clk edge that drives tck_o 0->1.
//   Idle: tck_o held 0, tms_o held 0 (stay in Run-Test/Idle).
//  FSM: TLR -> IDLE -> HDR -> SHIFT -> TAIL -> RESP -> IDLE.
//   TLR : 5 TCK with TMS=1, then 1 TCK with TMS=0 (Run-Test/Idle). Entered on reset release and cmd_tlr.
//   IDLE: cmd_ready=1 only here and only when rsp_valid=0; accept on cmd_valid&&cmd_ready.
//   HDR : DR TMS=1,0,0 (3 TCK); IR TMS=1,1,0,0 (4 TCK) -> Shift-xR. TDI=0 during HDR.
//   SHIFT: len TCK; tdi_o=cmd_data[i]; TMS=0 except last bit TMS=1 (Exit1). TDO captured into bit i.
//   TAIL: TMS=1 (Update-xR), TMS=0 (Run-Test/Idle): 2 TCK.
//   RESP: rsp_valid=1, rsp_data stable until rsp_valid&&rsp_ready; then IDLE.
//  cmd_tlr: runs TLR then RESP with rsp_data=0.
//  cmd_len=0: no TCK activity; RESP next cycle with rsp_data=0. cmd_len>MAX_LEN: clamped to MAX_LEN.
//  cmd_data latched at accept; later changes on cmd_* have no effect.
//  rsp_ready while rsp_valid=0: ignored. rsp_valid and cmd_ready never both 1.
//  Async rst mid-scan: outputs return to reset values immediately; scan abandoned, no response;
//   on release the TLR sequence runs before cmd_ready rises.
// CONFIGURATION
//  MFP_JTAG_MASTER_TRST_EN defined: trst_n_o=0 during rst and held 0 for the first 2*CLK_DIV clk of
//   every TLR sequence, then 1; TMS-based TLR still performed.
//  Not defined: trst_n_o tied 1; target reset solely via the TMS TLR sequence.
// TESTING  (CLK_DIV=2, MAX_LEN=32; bench TAP model checks TMS path, counts TCK rising edges)
//  1 rst pulse -> 6 TCK (TMS 1,1,1,1,1,0), TAP model in Run-Test/Idle, cmd_ready=1 at 24 clk after release.
//  2 IR scan len=5 data=0x01, model IR capture 0x01 -> 11 TCK (TMS 1,1,0,0,0,0,0,0,1,1,0), rsp_data=0x01, model IR=0x01.
//  3 DR scan len=32 data=0xA5A5_0F0F, model DR capture 0x1234_5678 -> 37 TCK, rsp_data=0x12345678, model DR=0xA5A50F0F.
//  4 cmd_len=0 -> zero TCK edges, rsp_valid next cycle, rsp_data=0; cmd_len=40 -> 32 shift bits.
//  5 hold rsp_ready=0 for 10 clk -> rsp_valid/rsp_data stable, cmd_ready=0; new cmd_valid not accepted.
//  6 assert rst at bit 10 of a 32-bit DR scan -> tck_o=0,tms_o=1 same cycle, no rsp; TLR rerun; with/without
//    MFP_JTAG_MASTER_TRST_EN check trst_n_o low 4 clk into TLR / constantly 1.

Source files
------------

// File: rtl/mfp_jtag_tap_master.sv
// JTAG/EJTAG TAP initiator: turns IR/DR scan commands into TCK/TMS/TDI sequences.
// Optional MFP_JTAG_MASTER_TRST_EN drives TRST_N low at the start of every TLR sequence.
module mfp_jtag_tap_master #(
  parameter int CLK_DIV = 4,
  parameter int MAX_LEN = 32,
  parameter int LEN_W   = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_tlr,
  input  logic               cmd_ir,
  input  logic [LEN_W-1:0]   cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               tck_o,
  output logic               tms_o,
  output logic               tdi_o,
  output logic               trst_n_o,
  input  logic               tdo_i
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] ONE      = LEN_W'(1);

  typedef enum logic [2:0] {
    S_TLR, S_IDLE, S_HDR, S_SHIFT, S_TAIL, S_RESP
  } state_t;

  state_t             state;
  state_t             nxt_state;
  logic [LEN_W-1:0]   idx;
  logic [LEN_W-1:0]   nxt_idx;
  logic [DIV_W-1:0]   div_cnt;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   len_c;
  logic [MAX_LEN-1:0] data_q;
  logic               ir_q;
  logic               tlr_q;
  logic               nxt_tms;
  logic               nxt_tdi;
  logic               accept;

  assign len_c  = (cmd_len > LEN_MAX) ? LEN_MAX : cmd_len;
  assign accept = (state == S_IDLE) && cmd_valid && cmd_ready;

  // Successor of the bit now ending, plus the TMS/TDI it needs.
  always_comb begin
    nxt_state = state;
    nxt_idx   = idx + ONE;
    unique case (state)
      S_TLR: if (idx == LEN_W'(5)) begin
        nxt_state = tlr_q ? S_RESP : S_IDLE;
        nxt_idx   = '0;
      end
      S_HDR: if (idx == (ir_q ? LEN_W'(3) : LEN_W'(2))) begin
        nxt_state = S_SHIFT;
        nxt_idx   = '0;
      end
      S_SHIFT: if (idx == len_q - ONE) begin
        nxt_state = S_TAIL;
        nxt_idx   = '0;
      end
      S_TAIL: if (idx == ONE) begin
        nxt_state = S_RESP;
        nxt_idx   = '0;
      end
      default: nxt_idx = idx;
    endcase
    nxt_tms = 1'b0;
    nxt_tdi = 1'b0;
    unique case (nxt_state)
      S_TLR:   nxt_tms = nxt_idx < LEN_W'(5);
      S_HDR:   nxt_tms = (nxt_idx == '0) || (ir_q && nxt_idx == ONE);
      S_SHIFT: begin
        nxt_tms = nxt_idx == len_q - ONE;
        nxt_tdi = data_q[nxt_idx[IDX_W-1:0]];
      end
      S_TAIL:  nxt_tms = nxt_idx == '0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_TLR;
      idx       <= '0;
      div_cnt   <= '0;
      tck_o     <= 1'b0;
      tms_o     <= 1'b1;
      tdi_o     <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      len_q     <= '0;
      data_q    <= '0;
      ir_q      <= 1'b0;
      tlr_q     <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: if (accept) begin
          cmd_ready <= 1'b0;
          rsp_data  <= '0;
          idx       <= '0;
          div_cnt   <= '0;
          tlr_q     <= cmd_tlr;
          ir_q      <= cmd_ir;
          len_q     <= len_c;
          data_q    <= cmd_data;
          if (cmd_tlr) begin
            state <= S_TLR;
            tms_o <= 1'b1;
          end else if (len_c == '0) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
          end else begin
            state <= S_HDR;
            tms_o <= 1'b1;
          end
        end
        S_RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: begin
          if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + DIV_ONE;
          end else begin
            div_cnt <= '0;
            if (!tck_o) begin
              tck_o <= 1'b1;
              if (state == S_SHIFT) rsp_data[idx[IDX_W-1:0]] <= tdo_i;
            end else begin
              tck_o <= 1'b0;
              state <= nxt_state;
              idx   <= nxt_idx;
              tms_o <= nxt_tms;
              tdi_o <= nxt_tdi;
              if (nxt_state == S_IDLE) cmd_ready <= 1'b1;
              if (nxt_state == S_RESP) rsp_valid <= 1'b1;
            end
          end
        end
      endcase
    end
  end

`ifdef MFP_JTAG_MASTER_TRST_EN
  logic trst_q;

  // Low through the first TCK bit of each TLR sequence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trst_q <= 1'b0;
    end else if (accept && cmd_tlr) begin
      trst_q <= 1'b0;
    end else if (state == S_TLR && tck_o && div_cnt == DIV_LAST) begin
      trst_q <= 1'b1;
    end
  end

  assign trst_n_o = trst_q;
`else
  assign trst_n_o = 1'b1;
`endif

endmodule

// File: tb/tb_mfp_jtag_tap_master.sv
// Directed bench for mfp_jtag_tap_master against a behavioural TAP target.
// Build with or without MFP_JTAG_MASTER_TRST_EN.
module tb_mfp_jtag_tap_master;

  localparam int CLK_DIV = 2;
`ifdef MFP_JTAG_MASTER_TRST_EN
  localparam int TRST_LOW = 2 * CLK_DIV;
  localparam logic TRST_RST = 1'b0;
`else
  localparam int TRST_LOW = 0;
  localparam logic TRST_RST = 1'b1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_tlr, cmd_ir;
  logic [5:0]  cmd_len;
  logic [31:0] cmd_data;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        tck_o, tms_o, tdi_o, trst_n_o, tdo;

  int nvec = 0;
  int nbad = 0;

  always #5 clk = ~clk;

  mfp_jtag_tap_master #(.CLK_DIV(CLK_DIV), .MAX_LEN(32), .LEN_W(6)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_tlr(cmd_tlr), .cmd_ir(cmd_ir),
    .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data),
    .tck_o(tck_o), .tms_o(tms_o), .tdi_o(tdi_o),
    .trst_n_o(trst_n_o), .tdo_i(tdo)
  );

  // Behavioural TAP target
  typedef enum logic [3:0] {
    T_TLR, T_RTI, T_SDR, T_CDR, T_SHDR, T_E1DR, T_PDR, T_E2DR,
    T_UDR, T_SIR, T_CIR, T_SHIR, T_E1IR, T_PIR, T_E2IR, T_UIR
  } tap_t;

  function automatic tap_t tap_next(tap_t s, logic m);
    case (s)
      T_TLR:  return m ? T_TLR  : T_RTI;
      T_RTI:  return m ? T_SDR  : T_RTI;
      T_SDR:  return m ? T_SIR  : T_CDR;
      T_CDR:  return m ? T_E1DR : T_SHDR;
      T_SHDR: return m ? T_E1DR : T_SHDR;
      T_E1DR: return m ? T_UDR  : T_PDR;
      T_PDR:  return m ? T_E2DR : T_PDR;
      T_E2DR: return m ? T_UDR  : T_SHDR;
      T_UDR:  return m ? T_SDR  : T_RTI;
      T_SIR:  return m ? T_TLR  : T_CIR;
      T_CIR:  return m ? T_E1IR : T_SHIR;
      T_SHIR: return m ? T_E1IR : T_SHIR;
      T_E1IR: return m ? T_UIR  : T_PIR;
      T_PIR:  return m ? T_E2IR : T_PIR;
      T_E2IR: return m ? T_UIR  : T_SHIR;
      default: return m ? T_SDR : T_RTI;
    endcase
  endfunction

  tap_t        tap_st = T_SHDR;
  logic [4:0]  ir = 5'h1f, ir_sr = 5'h00, ir_cap = 5'h01;
  logic [31:0] dr = 32'h0, dr_sr = 32'h0, dr_cap = 32'h0;
  int          tck_n = 0;
  logic [63:0] tms_hist = 64'h0;

  assign tdo = (tap_st == T_SHIR) ? ir_sr[0] : dr_sr[0];

  always @(posedge tck_o or negedge trst_n_o) begin
    if (!trst_n_o) begin
      tap_st <= T_TLR;
    end else begin
      case (tap_st)
        T_CDR:  dr_sr <= dr_cap;
        T_SHDR: dr_sr <= {tdi_o, dr_sr[31:1]};
        T_UDR:  dr    <= dr_sr;
        T_CIR:  ir_sr <= ir_cap;
        T_SHIR: ir_sr <= {tdi_o, ir_sr[4:1]};
        T_UIR:  ir    <= ir_sr;
        default: ;
      endcase
      tap_st <= tap_next(tap_st, tms_o);
    end
  end

  always @(posedge tck_o) begin
    tck_n    <= tck_n + 1;
    tms_hist <= {tms_hist[62:0], tms_o};
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at the negedge where rst is released.
  task automatic tlr_check(input string p);
    int n, lowc, t0;
    n = 0; lowc = 0; t0 = tck_n;
    while (n < 200) begin
      if (!trst_n_o) lowc++;
      @(posedge clk); n++;
      @(negedge clk);
      if (cmd_ready) break;
    end
    chk({p, "_cyc"}, n, 24);
    chk({p, "_trst_low"}, lowc, TRST_LOW);
    chk({p, "_trst_end"}, trst_n_o, 1);
    chk({p, "_tck"}, tck_n - t0, 6);
    chk({p, "_tms"}, tms_hist[5:0], 6'b111110);
    chk({p, "_tap"}, tap_st, T_RTI);
    chk({p, "_tms_idle"}, {tck_o, tms_o, rsp_valid}, 3'b000);
  endtask

  task automatic do_cmd(input logic tlr, input logic irs,
                        input logic [5:0] len, input logic [31:0] data,
                        output int lat, output int dtck);
    int w, t0;
    w = 0;
    while (!cmd_ready && w < 1000) begin @(negedge clk); w++; end
    t0 = tck_n;
    cmd_valid = 1'b1; cmd_tlr = tlr; cmd_ir = irs;
    cmd_len = len; cmd_data = data;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_tlr = 1'b0; cmd_ir = ~irs;
    cmd_len = 6'd7; cmd_data = ~data;
    lat = 0;
    while (!rsp_valid && lat < 1000) begin @(negedge clk); lat++; end
    dtck = tck_n - t0;
  endtask

  task automatic pop(input string p);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({p, "_pop"}, {rsp_valid, cmd_ready}, 2'b01);
  endtask

  initial begin
    int lat, dt, w, t0, bad;
    logic [31:0] held;
    rst = 1'b1; cmd_valid = 1'b0; cmd_tlr = 1'b0; cmd_ir = 1'b0;
    cmd_len = '0; cmd_data = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outs", {tck_o, tms_o, tdi_o, cmd_ready, rsp_valid},
        5'b01000);
    chk("rst_data", rsp_data, 0);
    chk("rst_trst", trst_n_o, TRST_RST);
    rst = 1'b0;
    tlr_check("por");

    // IR scan, spec vector
    ir_cap = 5'h01;
    do_cmd(0, 1, 6'd5, 32'h01, lat, dt);
    chk("ir1_lat", lat, 44);
    chk("ir1_tck", dt, 11);
    chk("ir1_tms", tms_hist[10:0], 11'b11000000110);
    chk("ir1_rsp", rsp_data, 32'h01);
    chk("ir1_reg", ir, 5'h01);
    pop("ir1");

    ir_cap = 5'h15;
    do_cmd(0, 1, 6'd5, 32'h1E, lat, dt);
    chk("ir2_rsp", rsp_data, 32'h15);
    chk("ir2_reg", ir, 5'h1E);
    pop("ir2");

    // DR 32-bit
    dr_cap = 32'h1234_5678;
    do_cmd(0, 0, 6'd32, 32'hA5A5_0F0F, lat, dt);
    chk("dr32_lat", lat, 148);
    chk("dr32_tck", dt, 37);
    chk("dr32_tms", tms_hist[36:0], {3'b100, 31'd0, 3'b110});
    chk("dr32_rsp", rsp_data, 32'h1234_5678);
    chk("dr32_reg", dr, 32'hA5A5_0F0F);
    chk("dr32_tap", tap_st, T_RTI);
    pop("dr32");

    // short DR: bits above len must read 0
    dr_cap = 32'hFFFF_00C3;
    do_cmd(0, 0, 6'd8, 32'h0000_003C, lat, dt);
    chk("dr8_lat", lat, 52);
    chk("dr8_rsp", rsp_data, 32'h0000_00C3);
    chk("dr8_reg", dr, 32'h3CFF_FF00);
    pop("dr8");

    // zero length
    do_cmd(0, 0, 6'd0, 32'hFFFF_FFFF, lat, dt);
    chk("len0_lat", lat, 0);
    chk("len0_tck", dt, 0);
    chk("len0_rsp", rsp_data, 0);
    pop("len0");

    // over-length clamps to 32
    dr_cap = 32'hCAFE_F00D;
    do_cmd(0, 0, 6'd40, 32'hDEAD_BEEF, lat, dt);
    chk("len40_tck", dt, 37);
    chk("len40_rsp", rsp_data, 32'hCAFE_F00D);
    chk("len40_reg", dr, 32'hDEAD_BEEF);

    // response back-pressure
    held = rsp_data;
    cmd_valid = 1'b1; cmd_len = 6'd5;
    t0 = tck_n; bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!rsp_valid || rsp_data !== held || cmd_ready) bad++;
    end
    cmd_valid = 1'b0;
    chk("hold_stable", bad, 0);
    chk("hold_tck", tck_n - t0, 0);
    pop("hold");

    // TLR command
    do_cmd(1, 0, 6'd9, 32'h5555_5555, lat, dt);
    chk("tlrc_lat", lat, 24);
    chk("tlrc_tck", dt, 6);
    chk("tlrc_tms", tms_hist[5:0], 6'b111110);
    chk("tlrc_rsp", rsp_data, 0);
    chk("tlrc_tap", tap_st, T_RTI);
    pop("tlrc");

    // reset during bit 10 of a 32-bit DR shift
    dr_cap = 32'h0F0F_0F0F;
    cmd_valid = 1'b1; cmd_tlr = 1'b0; cmd_ir = 1'b0;
    cmd_len = 6'd32; cmd_data = 32'h3333_3333;
    t0 = tck_n;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    w = 0;
    while ((tck_n - t0) < 13 && w < 1000) begin @(negedge clk); w++; end
    chk("mid_tck_hi", {tck_o, tms_o}, 2'b10);
    rst = 1'b1;
    #1;
    chk("mid_rst_pins", {tck_o, tms_o, tdi_o}, 3'b010);
    chk("mid_rst_hs", {cmd_ready, rsp_valid}, 2'b00);
    chk("mid_rst_trst", trst_n_o, TRST_RST);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    tlr_check("mid");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
